// File: rtl/fetch_decode_queue.sv
// Fetch/decode front end: I-MEM request FSM, PC counter, instruction queue,
// branch-redirect flush, register operand resolve with prioritised forwarding.
module fetch_decode_queue #(
  parameter int                     WORD_LENGTH = 32,
  parameter int                     QUEUE_DEPTH = 4,
  parameter int                     NUM_BYPASS  = 2,
  parameter logic [WORD_LENGTH-1:0] RESET_PC    = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic                              imem_req,
  output logic [WORD_LENGTH-1:0]            imem_addr,
  input  logic                              imem_ack,
  input  logic [WORD_LENGTH-1:0]            imem_data,
  input  logic                              redirect_valid,
  input  logic [WORD_LENGTH-1:0]            redirect_addr,
  output logic [3:0]                        read_reg_id_a,
  output logic [3:0]                        read_reg_id_b,
  output logic [3:0]                        read_reg_id_x,
  input  logic [WORD_LENGTH-1:0]            read_reg_a,
  input  logic [WORD_LENGTH-1:0]            read_reg_b,
  input  logic [WORD_LENGTH-1:0]            read_reg_x,
  input  logic [NUM_BYPASS-1:0]             byp_valid,
  input  logic [4*NUM_BYPASS-1:0]           byp_id,
  input  logic [WORD_LENGTH*NUM_BYPASS-1:0] byp_val,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WORD_LENGTH-1:0]            out_instr,
  output logic [WORD_LENGTH-1:0]            out_pc,
  output logic [WORD_LENGTH-1:0]            val_a,
  output logic [WORD_LENGTH-1:0]            val_b,
  output logic [WORD_LENGTH-1:0]            val_x,
  output logic                              out_illegal
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_ADC  = 6'h01;
  localparam logic [5:0] OP_SBC  = 6'h02;
  localparam logic [5:0] OP_SUB  = 6'h03;
  localparam logic [5:0] OP_AND  = 6'h04;
  localparam logic [5:0] OP_OR   = 6'h05;
  localparam logic [5:0] OP_XOR  = 6'h06;
  localparam logic [5:0] OP_CMP  = 6'h07;
  localparam logic [5:0] OP_LD   = 6'h10;
  localparam logic [5:0] OP_ST   = 6'h11;
  localparam logic [5:0] OP_LDA  = 6'h12;
  localparam logic [5:0] OP_STA  = 6'h13;
  localparam logic [5:0] OP_NOP  = 6'h20;
  localparam logic [5:0] OP_JMP  = 6'h21;
  localparam logic [5:0] OP_BR   = 6'h22;
  localparam logic [5:0] OP_HALT = 6'h23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  fetch_state_t state_reg, state_next;

  logic [WORD_LENGTH-1:0] pc_reg;
  logic [WORD_LENGTH-1:0] req_addr_reg;
  logic [PTR_W-1:0]       head_reg;
  logic [PTR_W-1:0]       tail_reg;
  logic [CNT_W-1:0]       count_reg;

  logic [WORD_LENGTH-1:0] q_instr [QUEUE_DEPTH];
  logic [WORD_LENGTH-1:0] q_pc    [QUEUE_DEPTH];

  logic queue_full, queue_empty;
  logic issue, push, fire;

  assign queue_full  = (count_reg == CNT_W'(QUEUE_DEPTH));
  assign queue_empty = (count_reg == '0);

  // ---------------------------------------------------------------- fetch FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (!redirect_valid && !queue_full) state_next = ST_WAIT;
      ST_WAIT: begin
        if (imem_ack)            state_next = ST_IDLE;
        else if (redirect_valid) state_next = ST_DROP;
      end
      ST_DROP: if (imem_ack) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The request is raised combinationally from IDLE; an ack seen in IDLE is stale and ignored.
  always_comb begin
    issue     = 1'b0;
    imem_req  = 1'b0;
    imem_addr = pc_reg;
    case (state_reg)
      ST_IDLE: begin
        issue     = rst && !redirect_valid && !queue_full;
        imem_req  = issue;
        imem_addr = pc_reg;
      end
      ST_WAIT, ST_DROP: begin
        imem_req  = 1'b1;
        imem_addr = req_addr_reg;
      end
      default: begin
        imem_req  = 1'b0;
        imem_addr = pc_reg;
      end
    endcase
  end

  assign push = (state_reg == ST_WAIT) && imem_ack && !redirect_valid;
  assign fire = !queue_empty && (!out_valid || out_ready) && !redirect_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg       <= RESET_PC;
      req_addr_reg <= RESET_PC;
    end else begin
      if (issue)               req_addr_reg <= pc_reg;
      if (redirect_valid)      pc_reg <= redirect_addr;
      else if (push)           pc_reg <= pc_reg + WORD_LENGTH'(4);
    end
  end

  // ---------------------------------------------------------------- queue
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[tail_reg] <= imem_data;
      q_pc[tail_reg]    <= pc_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (redirect_valid) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + PTR_W'(1);
      if (fire) head_reg <= head_reg + PTR_W'(1);
      case ({push, fire})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------- decode
  logic [WORD_LENGTH-1:0] head_instr, head_pc;
  logic [5:0]             op;
  logic [1:0]             mode;
  logic [3:0]             id_a, id_b, id_x;
  logic                   use_imm_a, use_imm_b, illegal;
  logic [WORD_LENGTH-1:0] imm18, imm11;

  assign head_instr = q_instr[head_reg];
  assign head_pc    = q_pc[head_reg];
  assign op         = head_instr[31:26];
  assign mode       = head_instr[19:18];
  // imm18 takes its sign from bit 0, not bit 17.
  assign imm18 = {{(WORD_LENGTH-18){head_instr[0]}}, head_instr[17:0]};
  assign imm11 = {{(WORD_LENGTH-11){head_instr[4]}}, head_instr[15:5]};

  always_comb begin
    id_a      = 4'd0;
    id_b      = 4'd0;
    id_x      = 4'd0;
    use_imm_a = 1'b0;
    use_imm_b = 1'b0;
    illegal   = 1'b0;
    if (!queue_empty) begin
      case (op)
        OP_ADD, OP_ADC, OP_SBC, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP: begin
          case (mode)
            2'b00: begin
              id_a      = head_instr[25:22];
              use_imm_b = 1'b1;
            end
            2'b11: begin
              id_b      = head_instr[3:0];
              use_imm_a = 1'b1;
            end
            default: begin
              id_a = head_instr[7:4];
              id_b = head_instr[3:0];
            end
          endcase
        end
        OP_LD, OP_ST, OP_LDA, OP_STA: begin
          id_b = head_instr[7:4];
          id_x = head_instr[3:0];
        end
        OP_NOP, OP_JMP, OP_BR, OP_HALT: begin
          id_a = 4'd0;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  assign read_reg_id_a = id_a;
  assign read_reg_id_b = id_b;
  assign read_reg_id_x = id_x;

  // ---------------------------------------------------------------- operand resolve
  logic [3:0]             byp_id_arr  [NUM_BYPASS];
  logic [WORD_LENGTH-1:0] byp_val_arr [NUM_BYPASS];

  for (genvar gi = 0; gi < NUM_BYPASS; gi++) begin : g_byp
    assign byp_id_arr[gi]  = byp_id[4*gi +: 4];
    assign byp_val_arr[gi] = byp_val[WORD_LENGTH*gi +: WORD_LENGTH];
  end

  // Scanning from the highest index down lets the lowest matching index win.
  function automatic logic [WORD_LENGTH-1:0] resolve(
    input logic [3:0]             id,
    input logic [WORD_LENGTH-1:0] rd,
    input logic [NUM_BYPASS-1:0]  bv,
    input logic [3:0]             bid  [NUM_BYPASS],
    input logic [WORD_LENGTH-1:0] bval [NUM_BYPASS]
  );
    logic [WORD_LENGTH-1:0] v;
    v = rd;
    for (int i = NUM_BYPASS - 1; i >= 0; i--) begin
      if (bv[i] && (bid[i] == id)) v = bval[i];
    end
    if (id == 4'd0) v = '0;
    return v;
  endfunction

  logic [WORD_LENGTH-1:0] val_a_next, val_b_next, val_x_next;

  always_comb begin
    val_a_next = resolve(id_a, read_reg_a, byp_valid, byp_id_arr, byp_val_arr);
    val_b_next = resolve(id_b, read_reg_b, byp_valid, byp_id_arr, byp_val_arr);
    val_x_next = resolve(id_x, read_reg_x, byp_valid, byp_id_arr, byp_val_arr);
    if (use_imm_a) val_a_next = imm11;
    if (use_imm_b) val_b_next = imm18;
  end

  // ---------------------------------------------------------------- output bundle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
      val_a       <= '0;
      val_b       <= '0;
      val_x       <= '0;
      out_illegal <= 1'b0;
    end else if (redirect_valid) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid   <= 1'b1;
      out_instr   <= head_instr;
      out_pc      <= head_pc;
      val_a       <= val_a_next;
      val_b       <= val_b_next;
      val_x       <= val_x_next;
      out_illegal <= illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: instruction table with expected operands per
// forwarding configuration, memory model, scoreboard and redirect/reset sequences.
module tb_fetch_decode_queue;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          imem_req, imem_ack;
  logic [W-1:0]  imem_addr, imem_data;
  logic          redirect_valid;
  logic [W-1:0]  redirect_addr;
  logic [3:0]    read_reg_id_a, read_reg_id_b, read_reg_id_x;
  logic [W-1:0]  read_reg_a, read_reg_b, read_reg_x;
  logic [1:0]    byp_valid;
  logic [7:0]    byp_id;
  logic [63:0]   byp_val;
  logic          out_valid, out_ready, out_illegal;
  logic [W-1:0]  out_instr, out_pc, val_a, val_b, val_x;

  fetch_decode_queue dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .read_reg_id_a(read_reg_id_a), .read_reg_id_b(read_reg_id_b), .read_reg_id_x(read_reg_id_x),
    .read_reg_a(read_reg_a), .read_reg_b(read_reg_b), .read_reg_x(read_reg_x),
    .byp_valid(byp_valid), .byp_id(byp_id), .byp_val(byp_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .val_a(val_a), .val_b(val_b), .val_x(val_x), .out_illegal(out_illegal)
  );

  logic [W-1:0] gr [16];
  assign read_reg_a = gr[read_reg_id_a];
  assign read_reg_b = gr[read_reg_id_b];
  assign read_reg_x = gr[read_reg_id_x];

  // config 0: both forwarders valid on r5 (0xAA, 0xBB); config 1: only entry 1 valid, on r7 (0xCC)
  typedef struct packed {
    logic [31:0] instr, a0, b0, x0, a1, b1, x1;
    logic        ill;
  } vec_t;
  typedef struct packed {
    logic [31:0] pc, instr, a, b, x;
    logic        ill;
  } exp_t;

  vec_t vt [16];
  exp_t sb [$];

  int checks = 0, errors = 0;
  int cyc = 0, n_tx = 0, n_req = 0;
  int first_req = -1, first_val = -1;

  logic         nxt_rst = 1'b0, nxt_ready = 1'b1, nxt_redir = 1'b0, nxt_cfg = 1'b0, cfg = 1'b0;
  logic [W-1:0] nxt_raddr = '0;
  logic         m_pending = 1'b0, m_drop = 1'b0, m_stray = 1'b0, chk_after_redir = 1'b0;
  logic [W-1:0] m_addr = '0, exp_fetch = '0;
  int           m_wait = 0, mem_lat = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic set_row(input int i, input logic [31:0] instr,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] x0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [31:0] x1,
                         input logic ill);
    vt[i] = '{instr: instr, a0: a0, b0: b0, x0: x0, a1: a1, b1: b1, x1: x1, ill: ill};
  endtask

  function automatic bit outputs_zero();
    return !imem_req && imem_addr == 0 && !out_valid && out_instr == 0 && out_pc == 0 &&
           val_a == 0 && val_b == 0 && val_x == 0 && !out_illegal &&
           read_reg_id_a == 0 && read_reg_id_b == 0 && read_reg_id_x == 0;
  endfunction

  task automatic sample();
    exp_t e;
    logic ack_real;
    if (!rst) begin
      sb.delete();
      m_pending = 1'b0; m_drop = 1'b0; chk_after_redir = 1'b0;
      exp_fetch = '0; first_req = -1; first_val = -1;
      return;
    end
    if (first_req < 0 && imem_req)  first_req = cyc;
    if (first_val < 0 && out_valid) first_val = cyc;
    if (chk_after_redir) begin
      check("valid_after_redirect", {31'd0, out_valid}, 32'd0);
      chk_after_redir = 1'b0;
    end
    if (out_valid && out_ready) begin
      n_tx++;
      $display("tx %0d pc=%08h instr=%08h a=%08h b=%08h x=%08h ill=%0b",
               n_tx, out_pc, out_instr, val_a, val_b, val_x, out_illegal);
      if (sb.size() == 0) begin
        check("unexpected_output", out_pc, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_instr", out_instr, e.instr);
        check("val_a", val_a, e.a);
        check("val_b", val_b, e.b);
        check("val_x", val_x, e.x);
        check("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
      end
    end
    ack_real = imem_ack && !m_stray;
    if (ack_real) begin
      if (!m_drop && !redirect_valid) begin
        e.pc    = m_addr;
        e.instr = vt[m_addr[5:2]].instr;
        e.a     = cfg ? vt[m_addr[5:2]].a1 : vt[m_addr[5:2]].a0;
        e.b     = cfg ? vt[m_addr[5:2]].b1 : vt[m_addr[5:2]].b0;
        e.x     = cfg ? vt[m_addr[5:2]].x1 : vt[m_addr[5:2]].x0;
        e.ill   = vt[m_addr[5:2]].ill;
        sb.push_back(e);
        exp_fetch = exp_fetch + 32'd4;
      end
      m_pending = 1'b0;
      m_drop    = 1'b0;
    end else if (m_pending) begin
      if (redirect_valid) m_drop = 1'b1;
      if (m_wait > 0) m_wait--;
    end
    m_stray = 1'b0;
    if (imem_req && !m_pending && !ack_real) begin
      check("imem_addr", imem_addr, exp_fetch);
      m_pending = 1'b1;
      m_addr    = imem_addr;
      m_wait    = mem_lat - 1;
      n_req++;
    end
    if (redirect_valid) begin
      sb.delete();
      exp_fetch = redirect_addr;
      chk_after_redir = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rst            = nxt_rst;
    out_ready      = nxt_ready;
    redirect_valid = nxt_redir;
    redirect_addr  = nxt_raddr;
    cfg            = nxt_cfg;
    byp_valid      = cfg ? 2'b10 : 2'b11;
    byp_id         = cfg ? {4'd7, 4'd5} : {4'd5, 4'd5};
    byp_val        = cfg ? {32'hCC, 32'hAA} : {32'hBB, 32'hAA};
    imem_ack       = (m_pending && m_wait == 0) || m_stray;
    imem_data      = m_stray ? 32'h1234_5678 : (imem_ack ? vt[m_addr[5:2]].instr : 32'h0);
    @(negedge clk);
    cyc++;
    sample();
  endtask

  task automatic wait_new_req();
    int start;
    start = n_req;
    for (int k = 0; k < 20 && n_req == start; k++) tick();
    check("new_req_seen", {31'd0, n_req != start}, 32'd1);
  endtask

  initial begin
    rst = 1'b0; imem_ack = 1'b0; imem_data = '0; redirect_valid = 1'b0; redirect_addr = '0;
    out_ready = 1'b1; byp_valid = '0; byp_id = '0; byp_val = '0;
    for (int i = 0; i < 16; i++) gr[i] = 32'h100 + i;
    gr[0] = 32'hDEAD_BEEF; gr[3] = 32'h10; gr[5] = 32'h55; gr[7] = 32'h77; gr[9] = 32'h99;
    //          instr         a0          b0          x0    a1          b1          x1    ill
    set_row(0,  32'h00C3FFFF, 32'h10,     32'hFFFFFFFF, 0,  32'h10,     32'hFFFFFFFF, 0,  0);
    set_row(1,  32'h0C040050, 32'hAA,     0,          0,    32'h55,     0,          0,    0);
    set_row(2,  32'h10080079, 32'h77,     32'h99,     0,    32'hCC,     32'h99,     0,    0);
    set_row(3,  32'h140C2475, 32'hFFFFF923, 32'hAA,   0,    32'hFFFFF923, 32'h55,   0,    0);
    set_row(4,  32'h1802AAAA, 0,          32'h2AAAA,  0,    0,          32'h2AAAA,  0,    0);
    set_row(5,  32'h4000FF75, 0,          32'h77,     32'hAA, 0,        32'hCC,     32'h55, 0);
    set_row(6,  32'h4C000030, 0,          32'h10,     0,    0,          32'h10,     0,    0);
    set_row(7,  32'h80000055, 0,          0,          0,    0,          0,          0,    0);
    set_row(8,  32'hFC000055, 0,          0,          0,    0,          0,          0,    1);
    set_row(9,  32'h1C040093, 32'h99,     32'h10,     0,    32'h99,     32'h10,     0,    0);
    set_row(10, 32'h48000093, 0,          32'h99,     32'h10, 0,        32'h99,     32'h10, 0);
    set_row(11, 32'h84000077, 0,          0,          0,    0,          0,          0,    0);
    for (int i = 12; i < 16; i++) set_row(i, 32'h80000000, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) tick();
    check("reset_outputs_zero", {31'd0, outputs_zero()}, 32'd1);

    // streaming pass, forwarding config 0
    nxt_rst = 1'b1;
    repeat (30) tick();
    check("first_valid_latency", first_val - first_req, 32'd3);

    // redirect back to 0 and re-run the table under forwarding config 1
    nxt_redir = 1'b1; nxt_raddr = 32'h0; nxt_cfg = 1'b1;
    tick();
    nxt_redir = 1'b0;
    repeat (30) tick();

    // backpressure: queue fills, fetch stops, then drains in order
    nxt_ready = 1'b0;
    repeat (12) tick();
    check("req_low_when_full", {31'd0, imem_req}, 32'd0);
    check("held_valid", {31'd0, out_valid}, 32'd1);
    nxt_ready = 1'b1;
    repeat (20) tick();

    // redirect while waiting, ack arrives later and is dropped
    mem_lat = 3;
    wait_new_req();
    nxt_redir = 1'b1; nxt_raddr = 32'h100;
    tick();
    nxt_redir = 1'b0;
    repeat (25) tick();

    // redirect in the same cycle as the ack
    mem_lat = 1;
    wait_new_req();
    nxt_redir = 1'b1; nxt_raddr = 32'h40;
    tick();
    nxt_redir = 1'b0;
    repeat (20) tick();

    // asynchronous reset while a request is outstanding
    mem_lat = 3;
    wait_new_req();
    tick();
    #2;
    rst = 1'b0; nxt_rst = 1'b0;
    #1;
    check("async_reset_zero", {31'd0, outputs_zero()}, 32'd1);
    repeat (2) tick();
    mem_lat = 1;
    m_stray = 1'b1;
    nxt_rst = 1'b1;
    tick();
    repeat (20) tick();

    check("enough_transactions", {31'd0, n_tx >= 40}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
Parametrised successor of the single-cycle fetch/decode stage. Adds a real instruction-memory handshake, a PC counter, a QUEUE_DEPTH instruction queue, and a branch-redirect flush. Also adds NUM_BYPASS prioritised forwarding sources and a valid/ready output handshake. Sits between the I-MEM interface and the execute stage, and drives the general register file read ports A/B/X.

Parameters:
WORD_LENGTH, 32, datapath and instruction width
QUEUE_DEPTH, 4, instruction queue entries (power of 2, >=2)
NUM_BYPASS, 2, forwarding sources; index 0 highest priority
RESET_PC, 0, fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  WORD_LENGTH  fetch address, word aligned
imem_ack  in  1  data valid this cycle, completes request
imem_data  in  WORD_LENGTH  fetched instruction
redirect_valid  in  1  flush and restart fetch
redirect_addr  in  WORD_LENGTH  new fetch address
read_reg_id_a/b/x  out  4 each  register file read indexes (combinational from queue head)
read_reg_a/b/x  in  WORD_LENGTH each  register file read data (combinational)
byp_valid  in  NUM_BYPASS  forwarding entry valid
byp_id  in  4*NUM_BYPASS  forwarding destination register ids
byp_val  in  WORD_LENGTH*NUM_BYPASS  forwarding values
out_valid  out  1  output bundle valid
out_ready  in  1  execute stage accepts
out_instr, out_pc  out  WORD_LENGTH each  decoded instruction and its address
val_a, val_b, val_x  out  WORD_LENGTH each  operand values
out_illegal  out  1  opcode undefined

Behaviour:
- Reset (async, active-low): pc=RESET_PC; queue empty; fetch FSM=IDLE; imem_req=0; out_valid=0. All out_* and val_* are 0. Reset mid-request abandons the request; a later ack is ignored.
- Fetch FSM IDLE/WAIT/DROP, at most one outstanding request:
  - IDLE->WAIT when count<QUEUE_DEPTH and no redirect; imem_req=1, imem_addr=pc.
  - WAIT: on imem_ack, push {imem_data,pc}, pc+=4 (mod 2^WORD_LENGTH), return to IDLE. Next request issues the following cycle.
  - Redirect in WAIT without ack -> DROP. DROP waits for ack, discards it, -> IDLE.
  - Redirect in WAIT with ack in the same cycle -> data discarded, -> IDLE.
- Redirect, any state: pc=redirect_addr, queue cleared, out_valid=0 next cycle. Redirect wins over a same-cycle push, pop, or decode. First new request is imem_req=1 the cycle after redirect (IDLE case).
- Queue: circular, wrap-around pointers, count 0..QUEUE_DEPTH. Push and pop in the same cycle is legal, including when full or empty+push: no bypass of the queue, so there is 1 cycle minimum latency from ack to decode.
- Decode fire = queue non-empty and (!out_valid or out_ready) and !redirect. On fire: pop head, register outputs. Otherwise, out_ready=1 clears out_valid. Otherwise, outputs hold stable.
- Decode, head instruction op=instr[31:26], opcodes per shared defines:
  - ALU class (ADD,ADC,SBC,SUB,AND,OR,XOR,CMP), mode=instr[19:18]:
    - 00: A=instr[25:22]; val_a=GR[A]; val_b=imm18={{14{instr[0]}},instr[17:0]}.
    - 01/10: A=instr[7:4], B=instr[3:0]; val_a=GR[A], val_b=GR[B].
    - 11: B=instr[3:0]; val_a=imm11={{21{instr[4]}},instr[15:5]}; val_b=GR[B].
    - val_x=0 in all ALU modes.
  - LD/ST/LDA/STA: B=instr[7:4], X=instr[3:0]; val_a=0.
  - Other defined opcodes: all ids 0, all vals 0, legal.
  - Undefined opcode: out_illegal=1, vals 0; still handed off.
- Operand resolve, per port: id 0 reads 0 (never bypassed). Otherwise the lowest index i with byp_valid[i] and byp_id[i]==id supplies byp_val[i]. Otherwise read_reg_*. Unused ports drive id 0.

Test Plan:
- Reset release, imem_ack one cycle after each req, out_ready=1 -> addrs 0,4,8,...; first out_valid 3 cycles after first req; out_pc sequence 0,4,8.
- ADD mode 00, A=3, GR3=0x10, instr[17:0]=0x3FFFF with instr[0]=1 -> val_a=0x10, val_b=0xFFFFFFFF.
- out_ready=0 for 10 cycles -> queue fills to 4 plus 1 held output, imem_req drops; release -> no loss or duplication, in-order pc.
- Redirect to 0x100 while WAIT, late ack -> ack data dropped; next imem_addr=0x100; out_valid=0 cycle after redirect.
- byp0 and byp1 both valid with id 5 (0xAA,0xBB), mode 01 A=5, B=0 -> val_a=0xAA, val_b=0.
- Undefined opcode 0x3F -> out_illegal=1, val_a/b/x=0; async rst mid-WAIT -> all outputs 0 immediately.
